// File: rtl/sr_dbg_arb.sv
// Round-robin arbiter that shares the sr_cpu debug register read port among
// several observers: grant one request, drive regAddr, return regData two cycles later.
module sr_dbg_arb #(
    parameter int          N_REQ      = 4,
    parameter logic [4:0]  RESET_ADDR = 5'd10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*5-1:0]   req_addr,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [31:0]          rsp_data,
    output logic [4:0]           regAddr,
    input  logic [31:0]          regData,
    output logic                 busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PW-1:0]     r_ptr;
    logic [PW-1:0]     w_gnt_idx;
    logic [PW-1:0]     w_ptr_nxt;
    logic              w_found;
    logic [N_REQ-1:0]  w_gnt_oh;
    logic [N_REQ-1:0]  r_gnt_oh;
    logic [4:0]        r_reg_addr;
    logic              r_busy;
    logic [N_REQ-1:0]  r_rsp_valid;
    logic [31:0]       r_rsp_data;

    // (base + k) mod N_REQ; k never exceeds N_REQ so one subtraction suffices
    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end else begin
            s = s;
        end
        return s[PW-1:0];
    endfunction

    // Round-robin search for the first valid requester starting at the pointer
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_gnt_oh  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && req_valid[wrap_idx(r_ptr, k)]) begin
                w_found   = 1'b1;
                w_gnt_idx = wrap_idx(r_ptr, k);
            end else begin
                w_found   = w_found;
            end
        end
        if (w_found) begin
            for (int i = 0; i < N_REQ; i++) begin
                w_gnt_oh[i] = (PW'(i) == w_gnt_idx);
            end
        end else begin
            w_gnt_oh = '0;
        end
        w_ptr_nxt = wrap_idx(w_gnt_idx, 1);
    end

    // Next-state and acceptance decode; ready is suppressed while reset is held
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found && !rst) begin
                    req_ready   = w_gnt_oh;
                    w_state_nxt = ST_READ;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_READ: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant latch, address drive and response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_gnt_oh    <= '0;
            r_reg_addr  <= RESET_ADDR;
            r_busy      <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_data  <= 32'h0000_0000;
        end else begin
            r_busy      <= (w_state_nxt == ST_READ);
            r_rsp_valid <= '0;
            if (r_state == ST_IDLE && w_found) begin
                r_reg_addr <= req_addr[5*int'(w_gnt_idx) +: 5];
                r_gnt_oh   <= w_gnt_oh;
                r_ptr      <= w_ptr_nxt;
            end
            if (r_state == ST_READ) begin
                r_rsp_valid <= r_gnt_oh;
                r_rsp_data  <= regData;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign regAddr   = r_reg_addr;
    assign busy      = r_busy;

endmodule

// File: doc/sr_dbg_arb.md
# sr_dbg_arb

Round-robin arbiter and sequencer for the single debug register read port (`regAddr`/`regData`) of `sr_cpu`. Several on-chip observers (I/O monitor, pass/fail checker, trace unit, debugger) each issue register-read requests. The block grants one at a time, drives `regAddr`, samples `regData`, and returns the value to the winning requester. It sits between those observers and `sr_cpu`, in place of a directly driven `regAddr`.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 1..8.
- `RESET_ADDR`, default 5'd10: `regAddr` value after reset (a0, the I/O register).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in N_REQ: per-requester read request.
- `req_addr` in N_REQ*5: packed register addresses; requester i uses bits [5i+4:5i].
- `req_ready` out N_REQ: one-hot acceptance, combinational.
- `rsp_valid` out N_REQ: one-hot, one-cycle response pulse, registered.
- `rsp_data` out 32: read data, valid while any `rsp_valid` bit is high, registered.
- `regAddr` out 5: debug register address to `sr_cpu`, registered.
- `regData` in 32: debug register data from `sr_cpu`, combinational function of `regAddr`.
- `busy` out 1: high while in READ.

## Operation
- FSM has two states: IDLE and READ. Round-robin pointer `ptr` (0..N_REQ-1) holds the highest-priority index.
- IDLE:
  - Grant `g` is the first i with `req_valid[i]` = 1, searching `ptr`, `ptr+1`, … with wrap modulo N_REQ.
  - `req_ready[g]` = 1 in the same cycle; all other bits are 0.
  - On the edge: `regAddr` <= `req_addr[g]`, `g` is latched, `ptr` <= (g+1) mod N_REQ, state <= READ.
  - With no `req_valid` bit set, all `req_ready` bits are 0, the state stays IDLE, and `regAddr` holds its value.
- READ:
  - `req_ready` = 0 for all requesters.
  - On the edge: `rsp_data` <= `regData`, `rsp_valid` <= one-hot(g), state <= IDLE.
- `rsp_valid` clears after exactly one cycle unless a new sample sets it. It is never set in two consecutive cycles.
- `rsp_data` holds its last value when `rsp_valid` = 0.
- Handshake: a requester holds `req_valid` and `req_addr` stable until it sees `req_ready`. A request is consumed in the cycle where `req_valid` & `req_ready` are both high. To issue a new request, `req_valid` stays high in the cycle after acceptance; the arbiter treats it as new.
- Address 0 is forwarded unchanged; the returned value is whatever `regData` gives (0 for x0).
- Requests on `req_valid` that are unknown (X) during reset are ignored.
- Reset values: state IDLE, `ptr` 0, `req_ready` 0, `rsp_valid` 0, `rsp_data` 32'h0, `regAddr` = RESET_ADDR, `busy` 0.
- Reset while in READ aborts the transaction. No `rsp_valid` is produced for it, and the requester must re-request.
- N_REQ = 1 degenerates to a fixed grant with `ptr` constant at 0.

## Timing
- Request accepted in cycle t. `regAddr` is valid in cycle t+1. `regData` is sampled at the end of t+1. `rsp_valid`/`rsp_data` are visible in cycle t+2 (latency 2).
- The arbiter is back in IDLE in t+2 and can accept the next request in that same cycle, so responses overlap with new acceptance. Peak throughput is one read per 2 cycles.
- `req_ready` depends combinationally on `req_valid`, state and `ptr` only, never on `regData`.
- All outputs except `req_ready` are driven from flops.

## Test plan
- Reset: hold `rst` 2 cycles with `req_valid` = X, then release. Required: `regAddr` = 10, `rsp_valid` = 0, `rsp_data` = 0, `busy` = 0, and no `req_ready` during reset.
- Single read: bench models `regData` = 32'hA5A5_0000 | regAddr. Requester 2 asks for addr 7 at cycle t. Required: `req_ready` = 4'b0100 at t, `regAddr` = 7 at t+1, `rsp_valid` = 4'b0100 and `rsp_data` = 32'hA5A5_0007 at t+2.
- Fairness: all 4 requesters hold `req_valid` continuously with addrs 1, 2, 3, 4. Required: grant order 0,1,2,3,0,… with one grant every 2 cycles, and each `rsp_data` matches its own address.
- Wrap-around: `ptr` = 3 after a grant to 2; requesters 0 and 3 both request. Required: 3 is granted first, then 0.
- Reset mid-op: assert `rst` in the READ cycle. Required: no `rsp_valid` follows, the block is IDLE with `regAddr` = 10, and a re-request completes normally.
- System: with `sr_cpu` running the Fibonacci program, requester 0 polls addr 10. Required: `rsp_data` = 32'h00213d05 within 1000 cycles; for the Factorial program, 32'h1c8cfc00.
